dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache between the MEM stage and main memory.
//  Its miss output drives DCacheMiss into the hazard unit, which stalls the whole pipeline until the access completes.
//  Line refill and writeback are word-serial bursts over a simple request/ack memory port.
// PARAMETERS
//  LINE_ADDR_LEN  3   log2(words per line); 8 words per line
//  SET_ADDR_LEN   3   log2(number of sets); 8 sets
//  TAG_ADDR_LEN   (derived localparam) = 30-LINE_ADDR_LEN-SET_ADDR_LEN; byte addr[1:0] is ignored
// PORTS
//  clk        in   1   single clock; all state updates on the rising edge
//  rst_n      in   1   asynchronous, active-low reset
//  rd_req     in   1   load request from MEM stage
//  wr_req     in   1   store request from MEM stage
//  addr       in   32  byte address; word-aligned
//  wr_data    in   32  store data
//  wr_be      in   4   store byte enables; bit i covers byte i
//  rd_data    out  32  load data, registered
//  miss       out  1   combinational; high while the current request cannot complete (-> DCacheMiss)
//  miss_cnt   out  32  number of misses since reset
//  mem_req    out  1   burst active; held high for the whole burst
//  mem_we     out  1   1 = writeback burst, 0 = refill burst; stable while mem_req is high
//  mem_addr   out  30  word address of the current beat = line base + beat counter
//  mem_wdata  out  32  writeback data for the current beat
//  mem_rdata  in   32  refill data; valid when mem_ack is high
//  mem_ack    in   1   one pulse per completed beat
// BEHAVIOUR
//  Reset (async): state=IDLE; all valid and dirty bits = 0; rd_data=0; miss_cnt=0; mem_req=0;
//    mem_we=0; beat counter=0. Data and tag arrays are not cleared.
//  req = rd_req|wr_req. If both are high, the write is performed and rd_data is unchanged.
//  hit = valid[set] && tag[set]==addr tag, evaluated only in IDLE.
//  miss = req && !(state==IDLE && hit). The pipeline stalls, so request inputs are stable while miss is high.
//  Read hit: rd_data <= line word on the next edge. miss stays 0. No memory traffic.
//  Write hit: bytes selected by wr_be are merged into the word on the next edge; dirty[set] <= 1.
//  FSM:
//    IDLE -> SWAP_OUT   on req && !hit && valid && dirty.
//    IDLE -> SWAP_IN    on req && !hit && !(valid && dirty).
//    miss_cnt increments on the IDLE->SWAP_OUT or IDLE->SWAP_IN transition (wraps at 2^32).
//    SWAP_OUT: mem_we=1; mem_addr = {old tag, set, beat}; mem_wdata = line[beat].
//      On each mem_ack, beat++. On the last beat's ack: beat=0, go to SWAP_IN.
//    SWAP_IN: mem_we=0; mem_addr = {new tag, set, beat}.
//      On each mem_ack, line[beat] <= mem_rdata and beat++. On the last beat's ack -> SWAP_IN_OK.
//    SWAP_IN_OK: tag <= new tag; valid=1; dirty=0; mem_req=0; go to IDLE.
//      The re-evaluation in IDLE then hits and completes the access as a normal hit.
//  mem_req is high only in SWAP_OUT and SWAP_IN.
//    It drops for at least one cycle (SWAP_IN_OK) between bursts to different lines.
//    There is no drop between SWAP_OUT and SWAP_IN of the same miss.
//  Miss latency (clean line, N=2^LINE_ADDR_LEN, ack every cycle): miss high for N+2 cycles; data on the next edge.
//  Dirty miss adds N cycles.
//  mem_ack outside SWAP_OUT/SWAP_IN is ignored.
//    The beat counter wraps only via the explicit clear on the last beat.
//  rst_n low mid-burst: mem_req drops immediately and the partial line is discarded (valid=0).
//    Memory must tolerate an abandoned burst.
//  req low in IDLE: no state change; rd_data holds its value.
// STRUCTURE
//  Package dcache_pkg: state enum (IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK),
//    default LINE/SET lengths, address-field slicing functions.
//  Sub-module dcache_array holds tag/valid/dirty/data storage with byte-enable word write.
//    The FSM, beat counter and miss counter stay in dcache_ctrl.
// TESTING
//  1 Reset, then rd 0x40 -> miss=1 same cycle; refill beats at word addrs 0x10..0x17; miss=1 for 10 cycles;
//    rd_data = beat0 data next edge; miss_cnt=1.
//  2 rd 0x44 after T1 -> miss stays 0, no mem_req, rd_data = beat1 data next edge.
//  3 wr 0x44 data 0xDEADBEEF be 4'b0011 over 0x11112222 -> no mem traffic; rd 0x44 returns 0x1111BEEF.
//  4 rd 0x140 (same set, new tag) after T3 -> 8-beat writeback at words 0x10..0x17 (mem_we=1) carrying 0x1111BEEF at beat1,
//    then refill at words 0x50..0x57; miss_cnt=2.
//  5 rst_n low during beat 3 of refill -> mem_req=0 and miss_cnt=0 immediately; re-read of 0x40 misses again.
//  6 rd_req=wr_req=1 on hit addr 0x48 with data 0xA5A5A5A5 be 4'hF -> word written, dirty set, rd_data unchanged.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
package dcache_pkg;

   localparam int LINE_ADDR_LEN_DEF = 3;
   localparam int SET_ADDR_LEN_DEF  = 3;

   typedef enum logic [1:0] {
      IDLE,
      SWAP_OUT,
      SWAP_IN,
      SWAP_IN_OK
   } state_t;

   // Byte address bits [1:0] are dropped; fields are returned right-aligned.
   function automatic logic [31:0] word_idx(input logic [31:0] a, input int line_len);
      return (a >> 2) & ((32'd1 << line_len) - 32'd1);
   endfunction

   function automatic logic [31:0] set_idx(input logic [31:0] a, input int line_len,
                                           input int set_len);
      return (a >> (2 + line_len)) & ((32'd1 << set_len) - 32'd1);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] a, input int line_len,
                                          input int set_len);
      return a >> (2 + line_len + set_len);
   endfunction

endpackage

// File: rtl/dcache_if.sv
// MEM-stage request port and word-serial memory burst port of the data cache.
interface dcache_if;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_be;
   logic [31:0] rd_data;
   logic        miss;
   logic [31:0] miss_cnt;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  rd_req, wr_req, addr, wr_data, wr_be, mem_rdata, mem_ack,
      output rd_data, miss, miss_cnt, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output rd_req, wr_req, addr, wr_data, wr_be, mem_rdata, mem_ack,
      input  rd_data, miss, miss_cnt, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the cache; one set is addressed per cycle.
module dcache_array #(
   parameter int LINE_ADDR_LEN = 3,
   parameter int SET_ADDR_LEN  = 3,
   parameter int TAG_ADDR_LEN  = 30 - LINE_ADDR_LEN - SET_ADDR_LEN
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [SET_ADDR_LEN-1:0]  set,
   input  logic [LINE_ADDR_LEN-1:0] rword,
   input  logic [LINE_ADDR_LEN-1:0] bword,
   output logic [TAG_ADDR_LEN-1:0]  tag_q,
   output logic                     valid_q,
   output logic                     dirty_q,
   output logic [31:0]              rword_q,
   output logic [31:0]              bword_q,
   input  logic                     we,
   input  logic [LINE_ADDR_LEN-1:0] wword,
   input  logic [31:0]              wdata,
   input  logic [3:0]               wbe,
   input  logic                     dirty_set,
   input  logic                     fill_done,
   input  logic [TAG_ADDR_LEN-1:0]  fill_tag
);
   localparam int NSETS  = 1 << SET_ADDR_LEN;
   localparam int NWORDS = 1 << LINE_ADDR_LEN;

   logic [31:0]             data  [NSETS][NWORDS];
   logic [TAG_ADDR_LEN-1:0] tag   [NSETS];
   logic [NSETS-1:0]        valid;
   logic [NSETS-1:0]        dirty;

   assign tag_q   = tag[set];
   assign valid_q = valid[set];
   assign dirty_q = dirty[set];
   assign rword_q = data[set][rword];
   assign bword_q = data[set][bword];

   // Storage arrays carry no reset; only the line state bits do.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (wbe[b]) data[set][wword][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
      if (fill_done) tag[set] <= fill_tag;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= '0;
         dirty <= '0;
      end else if (fill_done) begin
         valid[set] <= 1'b1;
         dirty[set] <= 1'b0;
      end else if (dirty_set) begin
         dirty[set] <= 1'b1;
      end
   end
endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller with burst refill/writeback.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
   parameter int SET_ADDR_LEN  = SET_ADDR_LEN_DEF
) (
   input logic     clk,
   input logic     rst_n,
   dcache_if.slave bus
);
   localparam int TAG_ADDR_LEN = 30 - LINE_ADDR_LEN - SET_ADDR_LEN;
   localparam logic [LINE_ADDR_LEN-1:0] LAST_BEAT = '1;

   state_t                   state, state_n;
   logic [LINE_ADDR_LEN-1:0] beat, beat_n;
   logic [31:0]              miss_cnt_q, rd_data_q;

   logic [LINE_ADDR_LEN-1:0] cur_word;
   logic [SET_ADDR_LEN-1:0]  cur_set;
   logic [TAG_ADDR_LEN-1:0]  cur_tag;
   logic [TAG_ADDR_LEN-1:0]  tag_q;
   logic                     valid_q, dirty_q, hit, req;
   logic [31:0]              rword_q, bword_q;

   logic                     arr_we, dirty_set, fill_done, miss_inc, rd_load;
   logic [LINE_ADDR_LEN-1:0] arr_word;
   logic [31:0]              arr_wdata;
   logic [3:0]               arr_be;

   assign cur_word = LINE_ADDR_LEN'(word_idx(bus.addr, LINE_ADDR_LEN));
   assign cur_set  = SET_ADDR_LEN'(set_idx(bus.addr, LINE_ADDR_LEN, SET_ADDR_LEN));
   assign cur_tag  = TAG_ADDR_LEN'(tag_of(bus.addr, LINE_ADDR_LEN, SET_ADDR_LEN));

   assign req = bus.rd_req | bus.wr_req;
   assign hit = valid_q && (tag_q == cur_tag);

   dcache_array #(
      .LINE_ADDR_LEN(LINE_ADDR_LEN),
      .SET_ADDR_LEN (SET_ADDR_LEN),
      .TAG_ADDR_LEN (TAG_ADDR_LEN)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .set      (cur_set),
      .rword    (cur_word),
      .bword    (beat),
      .tag_q    (tag_q),
      .valid_q  (valid_q),
      .dirty_q  (dirty_q),
      .rword_q  (rword_q),
      .bword_q  (bword_q),
      .we       (arr_we),
      .wword    (arr_word),
      .wdata    (arr_wdata),
      .wbe      (arr_be),
      .dirty_set(dirty_set),
      .fill_done(fill_done),
      .fill_tag (cur_tag)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         beat       <= '0;
         miss_cnt_q <= '0;
         rd_data_q  <= '0;
      end else begin
         state <= state_n;
         beat  <= beat_n;
         if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
         if (rd_load)  rd_data_q  <= rword_q;
      end
   end

   // The request inputs are held stable by the pipeline stall, so the set and tag
   // decoded from addr stay valid for the whole writeback/refill sequence.
   always_comb begin
      state_n   = state;
      beat_n    = beat;
      arr_we    = 1'b0;
      arr_word  = cur_word;
      arr_wdata = bus.wr_data;
      arr_be    = bus.wr_be;
      dirty_set = 1'b0;
      fill_done = 1'b0;
      miss_inc  = 1'b0;
      rd_load   = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  if (bus.wr_req) begin
                     arr_we    = 1'b1;
                     dirty_set = 1'b1;
                  end else begin
                     rd_load = 1'b1;
                  end
               end else begin
                  miss_inc = 1'b1;
                  state_n  = (valid_q && dirty_q) ? SWAP_OUT : SWAP_IN;
               end
            end
         end
         SWAP_OUT: begin
            if (bus.mem_ack) begin
               if (beat == LAST_BEAT) begin
                  beat_n  = '0;
                  state_n = SWAP_IN;
               end else begin
                  beat_n = beat + 1'b1;
               end
            end
         end
         SWAP_IN: begin
            if (bus.mem_ack) begin
               arr_we    = 1'b1;
               arr_word  = beat;
               arr_wdata = bus.mem_rdata;
               arr_be    = 4'hF;
               if (beat == LAST_BEAT) begin
                  beat_n  = '0;
                  state_n = SWAP_IN_OK;
               end else begin
                  beat_n = beat + 1'b1;
               end
            end
         end
         SWAP_IN_OK: begin
            fill_done = 1'b1;
            state_n   = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.miss      = req && !((state == IDLE) && hit);
   assign bus.mem_req   = (state == SWAP_OUT) || (state == SWAP_IN);
   assign bus.mem_we    = (state == SWAP_OUT);
   assign bus.mem_addr  = {((state == SWAP_OUT) ? tag_q : cur_tag), cur_set, beat};
   assign bus.mem_wdata = bword_q;
   assign bus.rd_data   = rd_data_q;
   assign bus.miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: directed accesses, monitored memory beats and load data.
module tb_dcache_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dcache_if bus();
   dcache_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [31:0] mem [0:127];
   assign bus.mem_rdata = mem[bus.mem_addr[6:0]];
   assign bus.mem_ack   = bus.mem_req;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        we;
      logic [29:0] a;
      logic [31:0] d;
   } beat_t;

   beat_t       exp_beats[$];
   logic [31:0] exp_rd[$];
   logic        pend = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic push_refill(input logic [29:0] base);
      for (int i = 0; i < 8; i++) exp_beats.push_back({1'b0, base + 30'(i), 32'h0});
   endtask

   task automatic push_wb(input logic [29:0] base, input logic [31:0] d1, input logic [31:0] d2);
      logic [31:0] d;
      for (int i = 0; i < 8; i++) begin
         d = 32'hA000_0000 | (32'h10 + 32'(i));
         if (i == 1) d = d1;
         if (i == 2) d = d2;
         exp_beats.push_back({1'b1, base + 30'(i), d});
      end
   endtask

   // Monitor: compares every completed memory beat and every load result.
   initial begin
      beat_t e;
      forever begin
         @(negedge clk);
         #3;
         if (pend) begin
            if (exp_rd.size() == 0) begin
               total++; bad++;
               $display("FAIL rd_unexpected: got %h want none", bus.rd_data);
            end else chk("rd_data", bus.rd_data, exp_rd.pop_front());
         end
         pend = rst_n && bus.rd_req && !bus.wr_req && !bus.miss;
         if (rst_n && bus.mem_req && bus.mem_ack) begin
            if (exp_beats.size() == 0) begin
               total++; bad++;
               $display("FAIL beat_unexpected: got addr %h want none", bus.mem_addr);
            end else begin
               e = exp_beats.pop_front();
               chk("mem_we", 32'(bus.mem_we), 32'(e.we));
               chk("mem_addr", 32'(bus.mem_addr), 32'(e.a));
               if (e.we) chk("mem_wdata", bus.mem_wdata, e.d);
            end
            if (bus.mem_we) mem[bus.mem_addr[6:0]] = bus.mem_wdata;
         end
      end
   end

   task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         output int mc, output logic first);
      @(negedge clk);
      bus.rd_req = rd; bus.wr_req = wr; bus.addr = a; bus.wr_data = d; bus.wr_be = be;
      #1;
      first = bus.miss;
      mc = 0;
      while (bus.miss && mc < 200) begin
         mc++;
         @(negedge clk);
         #1;
      end
      if (mc >= 200) begin
         total++; bad++;
         $display("FAIL access_timeout: got miss stuck want completion at addr %h", a);
      end
      @(negedge clk);
      bus.rd_req = 1'b0; bus.wr_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1);
   end

   initial begin
      int   mc;
      logic first;
      for (int i = 0; i < 128; i++) mem[i] = 32'hC000_0000 | 32'(i);
      for (int i = 0; i < 8; i++) begin
         mem[8'h10 + i] = 32'hA000_0000 | (32'h10 + 32'(i));
         mem[8'h50 + i] = 32'hB000_0000 | (32'h50 + 32'(i));
      end
      mem[8'h11] = 32'h1111_2222;
      bus.rd_req = 1'b0; bus.wr_req = 1'b0; bus.addr = '0; bus.wr_data = '0; bus.wr_be = '0;

      repeat (3) @(negedge clk);
      #1;
      chk("rst_miss_cnt", bus.miss_cnt, 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_rd_data", bus.rd_data, 32'd0);
      chk("rst_miss", 32'(bus.miss), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Clean miss on 0x40: refill words 0x10..0x17.
      push_refill(30'h10);
      exp_rd.push_back(32'hA000_0010);
      access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, mc, first);
      chk("t1_miss_first", 32'(first), 32'd1);
      chk("t1_miss_cycles", 32'(mc), 32'd10);
      chk("t1_miss_cnt", bus.miss_cnt, 32'd1);

      exp_rd.push_back(32'h1111_2222);
      access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, mc, first);
      chk("t2_miss_cycles", 32'(mc), 32'd0);

      access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 4'b0011, mc, first);
      chk("t3_wr_miss_cycles", 32'(mc), 32'd0);
      exp_rd.push_back(32'h1111_BEEF);
      access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, mc, first);
      chk("t3_miss_cnt", bus.miss_cnt, 32'd1);

      // Dirty conflict miss: writeback then refill.
      push_wb(30'h10, 32'h1111_BEEF, 32'hA000_0012);
      push_refill(30'h50);
      exp_rd.push_back(32'hB000_0050);
      access(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, mc, first);
      chk("t4_miss_cycles", 32'(mc), 32'd18);
      chk("t4_miss_cnt", bus.miss_cnt, 32'd2);

      // Reset during refill beat 3.
      for (int i = 0; i < 3; i++) exp_beats.push_back({1'b0, 30'h10 + 30'(i), 32'h0});
      @(negedge clk);
      bus.rd_req = 1'b1; bus.addr = 32'h40;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      bus.rd_req = 1'b0;
      #1;
      chk("t5_mem_req", 32'(bus.mem_req), 32'd0);
      chk("t5_miss_cnt", bus.miss_cnt, 32'd0);
      chk("t5_rd_data", bus.rd_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      push_refill(30'h10);
      exp_rd.push_back(32'hA000_0010);
      access(1'b1, 1'b0, 32'h40, 32'h0, 4'h0, mc, first);
      chk("t5_remiss_cycles", 32'(mc), 32'd10);
      chk("t5_remiss_cnt", bus.miss_cnt, 32'd1);

      // Simultaneous read and write: write wins, rd_data untouched.
      access(1'b1, 1'b1, 32'h48, 32'hA5A5_A5A5, 4'hF, mc, first);
      chk("t6_miss_cycles", 32'(mc), 32'd0);
      chk("t6_rd_hold", bus.rd_data, 32'hA000_0010);
      exp_rd.push_back(32'hA5A5_A5A5);
      access(1'b1, 1'b0, 32'h48, 32'h0, 4'h0, mc, first);
      push_wb(30'h10, 32'h1111_BEEF, 32'hA5A5_A5A5);
      push_refill(30'h50);
      exp_rd.push_back(32'hB000_0050);
      access(1'b1, 1'b0, 32'h140, 32'h0, 4'h0, mc, first);
      chk("t6_dirty_cycles", 32'(mc), 32'd18);
      chk("t6_miss_cnt", bus.miss_cnt, 32'd2);

      repeat (3) @(negedge clk);
      chk("beats_left", 32'(exp_beats.size()), 32'd0);
      chk("rd_left", 32'(exp_rd.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
